flex_counter_mc: RTL and testbench

- Multi-channel, parametrised successor to the single-channel flex counter.
- Each of NUM_CH independent channels counts up or down under a selectable terminal mode: rollover-to-1, wrap-to-0, saturate, or one-shot.
- Each channel supports synchronous clear and parallel load, and produces registered rollover, zero, wrap-pulse and done flags.
- Used by timing and baud generators and APB-side timeout logic wherever several counters share one clock domain.

---
 rtl/flex_pkg.sv | 16 +
 rtl/flex_counter_ch.sv | 115 +++++++++++
 rtl/flex_counter_mc.sv | 64 ++++++
 tb/tb_flex_counter_mc.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/flex_pkg.sv
// rtl/flex_pkg.sv - shared mode encodings for the multi-channel flex counter
package flex_pkg;

    localparam logic [1:0] MODE_ROLL1   = 2'd0;
    localparam logic [1:0] MODE_WRAP    = 2'd1;
    localparam logic [1:0] MODE_SAT     = 2'd2;
    localparam logic [1:0] MODE_ONESHOT = 2'd3;

    typedef enum logic [1:0] {
        ROLL1   = MODE_ROLL1,
        WRAP    = MODE_WRAP,
        SAT     = MODE_SAT,
        ONESHOT = MODE_ONESHOT
    } cnt_mode_t;

endpackage

// File: rtl/flex_counter_ch.sv
// rtl/flex_counter_ch.sv - one counter channel: count register, next-state logic and flags
module flex_counter_ch
    import flex_pkg::*;
#(
    parameter int NUM_BITS = 4
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                clear,
    input  logic                load,
    input  logic [NUM_BITS-1:0] load_val,
    input  logic                count_enable,
    input  logic                dir,
    input  cnt_mode_t           mode,
    input  logic [NUM_BITS-1:0] rollover_val,
    output logic [NUM_BITS-1:0] count_out,
    output logic                rollover_flag,
    output logic                zero_flag,
    output logic                wrap_pulse,
    output logic                done,
    output logic                rollover_next
);

    logic [NUM_BITS-1:0] count_d, count_q;
    logic                rollover_flag_d, rollover_flag_q;
    logic                zero_flag_d, zero_flag_q;
    logic                wrap_pulse_d, wrap_pulse_q;
    logic                done_d, done_q;
    logic                term_dn;
    logic                rv_zero;

    // Next count and flags; flags are taken from the next count so they line up with count_out.
    always_comb begin
        count_d      = count_q;
        wrap_pulse_d = 1'b0;
        done_d       = done_q;
        rv_zero      = (rollover_val == '0);
        // ROLL1 lives in 1..rollover_val, so 1 is also a terminal value going down.
        term_dn      = (count_q == '0) || ((mode == ROLL1) && (count_q == 1));

        if (clear) begin
            count_d = '0;
            done_d  = 1'b0;
        end else if (load) begin
            count_d = load_val;
            done_d  = 1'b0;
        end else if (count_enable && !(done_q && (mode == ONESHOT))) begin
            if (dir) begin
                if (rv_zero) begin
                    // A zero terminal pins every mode at 0 and never wraps.
                    count_d = '0;
                    if (mode == ONESHOT) done_d = 1'b1;
                end else if (count_q >= rollover_val) begin
                    // Out-of-range counts are terminal too, so nothing counts through 2^NUM_BITS.
                    case (mode)
                        ROLL1: begin
                            count_d      = 1;
                            wrap_pulse_d = 1'b1;
                        end
                        WRAP: begin
                            count_d      = '0;
                            wrap_pulse_d = 1'b1;
                        end
                        ONESHOT: done_d = 1'b1;
                        default: count_d = count_q;
                    endcase
                end else begin
                    count_d = count_q + 1'b1;
                end
            end else begin
                if (term_dn) begin
                    case (mode)
                        ROLL1, WRAP: begin
                            count_d      = rollover_val;
                            wrap_pulse_d = !rv_zero;
                        end
                        ONESHOT: done_d = 1'b1;
                        default: count_d = count_q;
                    endcase
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
        end

        // Clear forces the rollover flag low even when rollover_val is 0.
        rollover_flag_d = (count_d == rollover_val) && !clear;
        zero_flag_d     = (count_d == '0);
    end

    // Count and flag registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q         <= '0;
            rollover_flag_q <= 1'b0;
            zero_flag_q     <= 1'b0;
            wrap_pulse_q    <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            count_q         <= count_d;
            rollover_flag_q <= rollover_flag_d;
            zero_flag_q     <= zero_flag_d;
            wrap_pulse_q    <= wrap_pulse_d;
            done_q          <= done_d;
        end
    end

    assign count_out     = count_q;
    assign rollover_flag = rollover_flag_q;
    assign zero_flag     = zero_flag_q;
    assign wrap_pulse    = wrap_pulse_q;
    assign done          = done_q;
    assign rollover_next = rollover_flag_d;

endmodule

// File: rtl/flex_counter_mc.sv
// rtl/flex_counter_mc.sv - NUM_CH independent flex counters sharing one clock
module flex_counter_mc
    import flex_pkg::*;
#(
    parameter int NUM_BITS = 4,
    parameter int NUM_CH   = 2
) (
    input  logic                         clk,
    input  logic                         n_rst,
    input  logic [NUM_CH-1:0]            clear,
    input  logic [NUM_CH-1:0]            load,
    input  logic [NUM_CH*NUM_BITS-1:0]   load_val,
    input  logic [NUM_CH-1:0]            count_enable,
    input  logic [NUM_CH-1:0]            dir,
    input  logic [NUM_CH*2-1:0]          mode,
    input  logic [NUM_CH*NUM_BITS-1:0]   rollover_val,
    output logic [NUM_CH*NUM_BITS-1:0]   count_out,
    output logic [NUM_CH-1:0]            rollover_flag,
    output logic [NUM_CH-1:0]            zero_flag,
    output logic [NUM_CH-1:0]            wrap_pulse,
    output logic [NUM_CH-1:0]            done,
    output logic                         any_rollover
);

    logic [NUM_CH-1:0] rollover_next;
    logic              any_rollover_d, any_rollover_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        flex_counter_ch #(.NUM_BITS(NUM_BITS)) u_ch (
            .clk          (clk),
            .n_rst        (n_rst),
            .clear        (clear[i]),
            .load         (load[i]),
            .load_val     (load_val[i*NUM_BITS +: NUM_BITS]),
            .count_enable (count_enable[i]),
            .dir          (dir[i]),
            .mode         (cnt_mode_t'(mode[i*2 +: 2])),
            .rollover_val (rollover_val[i*NUM_BITS +: NUM_BITS]),
            .count_out    (count_out[i*NUM_BITS +: NUM_BITS]),
            .rollover_flag(rollover_flag[i]),
            .zero_flag    (zero_flag[i]),
            .wrap_pulse   (wrap_pulse[i]),
            .done         (done[i]),
            .rollover_next(rollover_next[i])
        );
    end

    // Summary flag built from next-cycle channel flags so it matches rollover_flag timing.
    always_comb begin
        any_rollover_d = |rollover_next;
    end

    // Summary flag register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            any_rollover_q <= 1'b0;
        end else begin
            any_rollover_q <= any_rollover_d;
        end
    end

    assign any_rollover = any_rollover_q;

endmodule

// File: tb/tb_flex_counter_mc.sv
// tb/tb_flex_counter_mc.sv - self-checking bench for flex_counter_mc
module tb_flex_counter_mc;

    localparam int NB = 4;
    localparam int NC = 2;

    logic            clk = 1'b0;
    logic            n_rst;
    logic [NC-1:0]   clear, load, count_enable, dir;
    logic [NC*NB-1:0] load_val, rollover_val;
    logic [NC*2-1:0] mode;
    logic [NC*NB-1:0] count_out;
    logic [NC-1:0]   rollover_flag, zero_flag, wrap_pulse, done;
    logic            any_rollover;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int         ch;
        bit         clr, ld;
        logic [3:0] lv;
        bit         en, dr;
        logic [1:0] md;
        logic [3:0] rv;
        logic [3:0] e_cnt;
        bit         e_rf, e_zf, e_wp, e_dn;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    flex_counter_mc #(.NUM_BITS(NB), .NUM_CH(NC)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (clear),
        .load         (load),
        .load_val     (load_val),
        .count_enable (count_enable),
        .dir          (dir),
        .mode         (mode),
        .rollover_val (rollover_val),
        .count_out    (count_out),
        .rollover_flag(rollover_flag),
        .zero_flag    (zero_flag),
        .wrap_pulse   (wrap_pulse),
        .done         (done),
        .any_rollover (any_rollover)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(int ch, bit clr, bit ld, logic [3:0] lv, bit en, bit dr,
                                logic [1:0] md, logic [3:0] rv, logic [3:0] c,
                                bit rf, bit zf, bit wp, bit dn);
        vec_t v;
        v.ch = ch; v.clr = clr; v.ld = ld; v.lv = lv; v.en = en; v.dr = dr;
        v.md = md; v.rv = rv; v.e_cnt = c; v.e_rf = rf; v.e_zf = zf; v.e_wp = wp; v.e_dn = dn;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step(input vec_t v, input int idx);
        vec_t e;
        string tag;
        clear        = '0;
        load         = '0;
        count_enable = '0;
        clear[v.ch]                 = v.clr;
        load[v.ch]                  = v.ld;
        count_enable[v.ch]          = v.en;
        dir[v.ch]                   = v.dr;
        load_val[v.ch*NB +: NB]     = v.lv;
        mode[v.ch*2 +: 2]           = v.md;
        rollover_val[v.ch*NB +: NB] = v.rv;
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        tag = $sformatf("v%0d_ch%0d", idx, e.ch);
        chk({tag, "_count"}, 32'(count_out[e.ch*NB +: NB]), 32'(e.e_cnt));
        chk({tag, "_rollover"}, 32'(rollover_flag[e.ch]), 32'(e.e_rf));
        chk({tag, "_zero"}, 32'(zero_flag[e.ch]), 32'(e.e_zf));
        chk({tag, "_wrap"}, 32'(wrap_pulse[e.ch]), 32'(e.e_wp));
        chk({tag, "_done"}, 32'(done[e.ch]), 32'(e.e_dn));
    endtask

    initial begin
        n_rst = 1'b1;
        clear = '0; load = '0; count_enable = '0; dir = '0;
        load_val = '0; rollover_val = '0; mode = '0;

        // ch, clr, ld, lv, en, dir, mode, rv, exp count, rf, zf, wp, done
        // ROLL1 up, rv 5 (legacy)
        vecs.push_back(mk(0,0,0, 0,0,1,0, 5,  0,0,1,0,0));
        vecs.push_back(mk(0,0,0, 0,1,1,0, 5,  1,0,0,0,0));
        vecs.push_back(mk(0,0,0, 0,1,1,0, 5,  2,0,0,0,0));
        vecs.push_back(mk(0,0,0, 0,1,1,0, 5,  3,0,0,0,0));
        vecs.push_back(mk(0,0,0, 0,1,1,0, 5,  4,0,0,0,0));
        vecs.push_back(mk(0,0,0, 0,1,1,0, 5,  5,1,0,0,0));
        vecs.push_back(mk(0,0,0, 0,1,1,0, 5,  1,0,0,1,0));
        vecs.push_back(mk(0,0,0, 0,1,1,0, 5,  2,0,0,0,0));
        // WRAP down on ch1, rv 3
        vecs.push_back(mk(1,0,0, 0,1,0,1, 3,  3,1,0,1,0));
        vecs.push_back(mk(1,0,0, 0,1,0,1, 3,  2,0,0,0,0));
        vecs.push_back(mk(1,0,0, 0,1,0,1, 3,  1,0,0,0,0));
        vecs.push_back(mk(1,0,0, 0,1,0,1, 3,  0,0,1,0,0));
        vecs.push_back(mk(1,0,0, 0,1,0,1, 3,  3,1,0,1,0));
        // SAT up at 15, then SAT down from 2
        vecs.push_back(mk(0,0,1,13,0,1,2,15, 13,0,0,0,0));
        vecs.push_back(mk(0,0,0, 0,1,1,2,15, 14,0,0,0,0));
        vecs.push_back(mk(0,0,0, 0,1,1,2,15, 15,1,0,0,0));
        vecs.push_back(mk(0,0,0, 0,1,1,2,15, 15,1,0,0,0));
        vecs.push_back(mk(0,0,0, 0,1,1,2,15, 15,1,0,0,0));
        vecs.push_back(mk(0,0,1, 2,0,0,2,15,  2,0,0,0,0));
        vecs.push_back(mk(0,0,0, 0,1,0,2,15,  1,0,0,0,0));
        vecs.push_back(mk(0,0,0, 0,1,0,2,15,  0,0,1,0,0));
        vecs.push_back(mk(0,0,0, 0,1,0,2,15,  0,0,1,0,0));
        vecs.push_back(mk(0,0,0, 0,1,0,2,15,  0,0,1,0,0));
        // ONESHOT up on ch1, rv 4
        vecs.push_back(mk(1,1,0, 0,0,1,3, 4,  0,0,1,0,0));
        vecs.push_back(mk(1,0,0, 0,1,1,3, 4,  1,0,0,0,0));
        vecs.push_back(mk(1,0,0, 0,1,1,3, 4,  2,0,0,0,0));
        vecs.push_back(mk(1,0,0, 0,1,1,3, 4,  3,0,0,0,0));
        vecs.push_back(mk(1,0,0, 0,1,1,3, 4,  4,1,0,0,0));
        vecs.push_back(mk(1,0,0, 0,1,1,3, 4,  4,1,0,0,1));
        vecs.push_back(mk(1,0,0, 0,1,1,3, 4,  4,1,0,0,1));
        vecs.push_back(mk(1,0,1, 2,0,1,3, 4,  2,0,0,0,0));
        vecs.push_back(mk(1,0,0, 0,1,1,3, 4,  3,0,0,0,0));
        vecs.push_back(mk(1,0,0, 0,1,1,3, 4,  4,1,0,0,0));
        vecs.push_back(mk(1,0,0, 0,1,1,3, 4,  4,1,0,0,1));
        // clear beats load and enable, even with rv 0; then out-of-range load
        vecs.push_back(mk(0,1,1, 9,1,1,0, 0,  0,0,1,0,0));
        vecs.push_back(mk(0,0,1,12,0,1,0, 7, 12,0,0,0,0));
        vecs.push_back(mk(0,0,0, 0,1,1,0, 7,  1,0,0,1,0));
        // rv 0 counting up: pinned at 0, no wrap, ONESHOT still finishes
        vecs.push_back(mk(0,0,1, 3,0,1,1, 0,  3,0,0,0,0));
        vecs.push_back(mk(0,0,0, 0,1,1,1, 0,  0,1,1,0,0));
        vecs.push_back(mk(0,0,0, 0,1,1,1, 0,  0,1,1,0,0));
        vecs.push_back(mk(0,0,0, 0,1,1,3, 0,  0,1,1,0,1));
        vecs.push_back(mk(0,0,0, 0,1,1,2, 5,  1,0,0,0,1));
        vecs.push_back(mk(0,1,0, 0,0,1,2, 5,  0,0,1,0,0));
        // ROLL1 down, rv 5: 1 is terminal
        vecs.push_back(mk(0,0,1, 3,0,0,0, 5,  3,0,0,0,0));
        vecs.push_back(mk(0,0,0, 0,1,0,0, 5,  2,0,0,0,0));
        vecs.push_back(mk(0,0,0, 0,1,0,0, 5,  1,0,0,0,0));
        vecs.push_back(mk(0,0,0, 0,1,0,0, 5,  5,1,0,1,0));
        vecs.push_back(mk(0,0,0, 0,1,0,0, 5,  4,0,0,0,0));
        // out-of-range up: SAT holds, WRAP goes to 0
        vecs.push_back(mk(0,0,1, 9,0,1,2, 7,  9,0,0,0,0));
        vecs.push_back(mk(0,0,0, 0,1,1,2, 7,  9,0,0,0,0));
        vecs.push_back(mk(0,0,1, 9,0,1,1, 7,  9,0,0,0,0));
        vecs.push_back(mk(0,0,0, 0,1,1,1, 7,  0,0,1,1,0));

        // Asynchronous reset with no clock edge
        #7 n_rst = 1'b0;
        #1;
        chk("rst_count", 32'(count_out), 32'd0);
        chk("rst_rollover", 32'(rollover_flag), 32'd0);
        chk("rst_zero", 32'(zero_flag), 32'd0);
        chk("rst_wrap", 32'(wrap_pulse), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_any", 32'(any_rollover), 32'd0);
        @(negedge clk);
        n_rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i], i);
        end

        // Reset mid-count on both channels
        clear = '0; count_enable = '0;
        load = 2'b11;
        load_val = {4'd1, 4'd5};
        rollover_val = {4'd2, 4'd9};
        mode = {2'd0, 2'd0};
        dir = 2'b11;
        @(posedge clk); #1;
        load = '0;
        count_enable = 2'b11;
        @(posedge clk); #1;
        count_enable = '0;
        chk("mid_ch0_count", 32'(count_out[3:0]), 32'd6);
        chk("mid_ch1_count", 32'(count_out[7:4]), 32'd2);
        chk("mid_ch1_rollover", 32'(rollover_flag[1]), 32'd1);
        chk("mid_any", 32'(any_rollover), 32'd1);
        #2 n_rst = 1'b0;
        #1;
        chk("mid_rst_count", 32'(count_out), 32'd0);
        chk("mid_rst_flags", 32'({rollover_flag, zero_flag, wrap_pulse, done}), 32'd0);
        chk("mid_rst_any", 32'(any_rollover), 32'd0);
        @(negedge clk);
        n_rst = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_zero", 32'(zero_flag), 32'd3);
        chk("post_rst_count", 32'(count_out), 32'd0);
        chk("post_rst_sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
